mmio_data_memory: RTL and testbench
===================================

# mmio_data_memory

Parametrised data-memory subsystem for the processor bus: word-addressed RAM plus a memory-mapped I/O window with NIN sampled input channels (keyboard, buttons) carrying change-pending flags, and NOUT CPU-writable output registers (game state, colour). It sits between the processor's load/store port and the rest of the system. It supersedes the plain data memory, whose I/O was wired around it ad hoc. Reads are registered with a valid strobe; input changes raise an interrupt request.

## Interface
- BUS, 32: data and address width.
- MEMSIZE, 256: RAM depth in words, power of two, ≥ 2.
- NIN, 2: input channels, 1..8.
- NOUT, 2: output registers, 1..8.
- IOBASE, 32'h0000_1000: first word address of the I/O window; must be ≥ MEMSIZE.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- mre  in  1  read request, sampled on the clock edge.
- mwe  in  1  write request, sampled on the clock edge.
- addr  in  BUS  word address.
- wdata  in  BUS  write data.
- rdata  out  BUS  read data, registered.
- rvalid  out  1  one-cycle pulse: rdata holds the result of the previous-cycle read.
- in_data  in  NIN*BUS  input channels; channel k is bits [k*BUS +: BUS]; synchronous to clk.
- out_data  out  NOUT*BUS  output registers, packed the same way.
- irq  out  1  OR of all pending bits, registered.
- bus_err  out  1  sticky; cleared only by reset.

## Operation
- Address map (word addresses):
  - 0..MEMSIZE-1: RAM.
  - IOBASE+k, k<NIN: IN[k], read-only.
  - IOBASE+NIN: STATUS. Read returns pending[NIN-1:0], zero-extended. Write is W1C on pending.
  - IOBASE+NIN+1+j, j<NOUT: OUT[j], read/write.
  - Any other address: reads return 0 with rvalid; writes are dropped. Both set bus_err.
- Input channel k:
  - shadow[k] registers in_data[k] every cycle.
  - pending[k] sets when in_data[k] ≠ shadow[k].
  - A read of IN[k] returns shadow[k] and clears pending[k].
- Writes to IN[k] are dropped and set bus_err.
- mre and mwe both high: the write is performed, no read occurs, rvalid stays 0, bus_err sets.
- RAM contents are not reset.

## Timing
- Reset values: rdata 0, rvalid 0, out_data 0, shadow 0, pending 0, irq 0, bus_err 0. Reset asserted mid-transaction aborts it; no rvalid follows.
- Write: takes effect at the edge where mwe=1. A read of the same address in the next cycle returns the new value.
- Read: mre=1 at edge N gives rdata and rvalid=1 after edge N. rvalid drops after edge N+1 unless mre is repeated. rdata holds its value until the next read. Back-to-back reads give one result per cycle.
- Pending: a change on in_data visible at edge N sets pending at edge N and irq at edge N+1. A nonzero in_data at reset release sets pending on the first edge.
- Same-edge conflicts: set beats clear, for both the IN[k] read-clear and the STATUS W1C.
- out_data updates at the write edge.

## Structure
- Package mmio_pkg: address-offset functions (in_addr, status_addr, out_addr) and a decode enum {DEC_RAM, DEC_IN, DEC_STATUS, DEC_OUT, DEC_NONE}.
- Sub-module mmio_input_channel (shadow register, pending flag, set/clear priority), instantiated NIN times via generate.
- RAM is an inferred array with a synchronous read port.

## Test plan
- Reset, then write 32'hDEAD_BEEF to address 5 and read it back → rvalid one cycle after mre, rdata=32'hDEAD_BEEF. A read of address 6 → rdata=0 value is not required.
- in_data[0] changes 0→32'h0000_0041 → pending[0]=1, irq=1 one cycle later. Read IOBASE+0 → rdata=32'h41 and pending[0]=0. Read STATUS → 0.
- Change in_data[1] in the same cycle as a W1C write of 32'h2 to STATUS → pending[1] stays 1.
- Write 32'h00FF_00FF to OUT[1] (IOBASE+NIN+2) → out_data[2*BUS-1:BUS]=32'h00FF_00FF; readback matches.
- Read IOBASE+50 → rdata=0, rvalid=1, bus_err=1. Assert mre and mwe together on address 3 → RAM[3] written, rvalid=0.
- Assert reset mid-read with out_data nonzero → rvalid=0, out_data=0, bus_err=0 immediately (asynchronous).

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared address-map helpers and decode classes for the MMIO data memory.
package mmio_pkg;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_IN,
        DEC_STATUS,
        DEC_OUT,
        DEC_NONE
    } dec_e;

    function automatic logic [63:0] in_addr(
        input logic [63:0] base,
        input int          k
    );
        return base + 64'(k);
    endfunction

    function automatic logic [63:0] status_addr(
        input logic [63:0] base,
        input int          nin
    );
        return base + 64'(nin);
    endfunction

    function automatic logic [63:0] out_addr(
        input logic [63:0] base,
        input int          nin,
        input int          j
    );
        return base + 64'(nin) + 64'(j) + 64'd1;
    endfunction

endpackage

// File: rtl/mmio_input_channel.sv
// One sampled input channel: shadow register plus change-pending flag.
module mmio_input_channel #(
    parameter int BUS = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BUS-1:0] din,
    input  logic           clr,
    output logic [BUS-1:0] shadow,
    output logic           pending
);

    // A fresh change wins over a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            shadow  <= din;
            pending <= (din != shadow) | (pending & ~clr);
        end
    end

endmodule

// File: rtl/mmio_data_memory.sv
// Word-addressed RAM with an I/O window of input channels, status and
// output registers; registered reads with a valid strobe.
module mmio_data_memory
    import mmio_pkg::*;
#(
    parameter int             BUS     = 32,
    parameter int             MEMSIZE = 256,
    parameter int             NIN     = 2,
    parameter int             NOUT    = 2,
    parameter logic [BUS-1:0] IOBASE  = 'h1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mre,
    input  logic                mwe,
    input  logic [BUS-1:0]      addr,
    input  logic [BUS-1:0]      wdata,
    output logic [BUS-1:0]      rdata,
    output logic                rvalid,
    input  logic [NIN*BUS-1:0]  in_data,
    output logic [NOUT*BUS-1:0] out_data,
    output logic                irq,
    output logic                bus_err
);

    localparam int AW = $clog2(MEMSIZE);
    localparam logic [BUS-1:0] MEM_TOP = BUS'(MEMSIZE);
    localparam logic [BUS-1:0] ST_A =
        BUS'(status_addr(64'(IOBASE), NIN));

    dec_e                      dec;
    logic [NIN-1:0]            sel_in;
    logic [NOUT-1:0]           sel_out;
    logic [NIN-1:0]            clr;
    logic [NIN-1:0]            pending;
    logic [NIN-1:0][BUS-1:0]   shadow;
    logic [NOUT-1:0][BUS-1:0]  outr;
    logic [BUS-1:0]            mem [MEMSIZE];
    logic [BUS-1:0]            ram_q;
    logic [BUS-1:0]            io_d;
    logic [BUS-1:0]            io_q;
    logic                      rd_ram;
    logic                      rd;
    logic                      err_set;
    logic [AW-1:0]             ram_a;

    assign ram_a = addr[AW-1:0];
    // A simultaneous write suppresses the read.
    assign rd    = mre & ~mwe;

    always_comb begin
        dec     = DEC_NONE;
        sel_in  = '0;
        sel_out = '0;
        for (int k = 0; k < NIN; k++) begin
            if (addr == BUS'(in_addr(64'(IOBASE), k))) begin
                dec       = DEC_IN;
                sel_in[k] = 1'b1;
            end
        end
        if (addr == ST_A) dec = DEC_STATUS;
        for (int j = 0; j < NOUT; j++) begin
            if (addr == BUS'(out_addr(64'(IOBASE), NIN, j))) begin
                dec        = DEC_OUT;
                sel_out[j] = 1'b1;
            end
        end
        if (addr < MEM_TOP) dec = DEC_RAM;
    end

    assign err_set = ((mre | mwe) & (dec == DEC_NONE))
                   | (mwe & (dec == DEC_IN))
                   | (mre & mwe);

    always_comb begin
        io_d = '0;
        unique case (dec)
            DEC_IN: begin
                for (int k = 0; k < NIN; k++)
                    if (sel_in[k]) io_d = io_d | shadow[k];
            end
            DEC_STATUS: io_d = {{(BUS-NIN){1'b0}}, pending};
            DEC_OUT: begin
                for (int j = 0; j < NOUT; j++)
                    if (sel_out[j]) io_d = io_d | outr[j];
            end
            default: io_d = '0;
        endcase
    end

    for (genvar k = 0; k < NIN; k++) begin : g_in
        assign clr[k] = (rd & sel_in[k])
                      | (mwe & (dec == DEC_STATUS) & wdata[k]);
        mmio_input_channel #(.BUS(BUS)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .din     (in_data[k*BUS +: BUS]),
            .clr     (clr[k]),
            .shadow  (shadow[k]),
            .pending (pending[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid  <= 1'b0;
            rd_ram  <= 1'b0;
            io_q    <= '0;
            irq     <= 1'b0;
            bus_err <= 1'b0;
            outr    <= '0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                rd_ram <= (dec == DEC_RAM);
                io_q   <= io_d;
            end
            irq <= |pending;
            if (err_set) bus_err <= 1'b1;
            for (int j = 0; j < NOUT; j++)
                if (mwe && sel_out[j]) outr[j] <= wdata;
        end
    end

    // RAM has no reset; its read port only updates on a RAM read.
    always_ff @(posedge clk) begin
        if (mwe && dec == DEC_RAM) mem[ram_a] <= wdata;
        if (rd && dec == DEC_RAM) ram_q <= mem[ram_a];
    end

    assign rdata    = rd_ram ? ram_q : io_q;
    assign out_data = outr;

endmodule

// File: tb/tb_mmio_data_memory.sv
// Table-driven and randomized checks of mmio_data_memory against a
// simple array-based model of its address map.
module tb_mmio_data_memory;

    localparam logic [31:0] IOB = 32'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mre, mwe;
    logic [31:0] addr, wdata, rdata;
    logic        rvalid, irq, bus_err;
    logic [63:0] in_data, out_data;

    int checks = 0;
    int errors = 0;

    mmio_data_memory dut (
        .clk      (clk),
        .reset    (reset),
        .mre      (mre),
        .mwe      (mwe),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .in_data  (in_data),
        .out_data (out_data),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          re, we;
        logic [31:0] a, wd, in0, in1;
        bit          ev;
        logic [31:0] ed;
        bit          eirq, eerr;
        logic [31:0] eout1;
    } vec_t;

    vec_t vec[19];

    function automatic vec_t mk(bit re, bit we, logic [31:0] a,
        logic [31:0] wd, logic [31:0] in0, logic [31:0] in1, bit ev,
        logic [31:0] ed, bit eirq, bit eerr, logic [31:0] eout1);
        vec_t v;
        v.re = re; v.we = we; v.a = a; v.wd = wd;
        v.in0 = in0; v.in1 = in1; v.ev = ev; v.ed = ed;
        v.eirq = eirq; v.eerr = eerr; v.eout1 = eout1;
        return v;
    endfunction

    // Behavioural model state
    logic [31:0] m_ram [256];
    bit          m_known [256];
    logic [31:0] m_out [2];
    logic [31:0] m_shadow [2];
    bit   [1:0]  m_pend;
    bit          m_err, m_rvalid, m_rknown, m_irq;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_out[0] = '0; m_out[1] = '0;
        m_shadow[0] = '0; m_shadow[1] = '0;
        m_pend = '0; m_err = 0; m_rvalid = 0; m_irq = 0;
        m_rdata = '0; m_rknown = 1;
    endtask

    task automatic model_edge(input bit re, input bit we,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [63:0] din);
        bit [1:0] clrm = '0;
        bit [1:0] old_pend = m_pend;
        if (we) begin
            if (a < 256) begin
                m_ram[a] = wd; m_known[a] = 1;
            end else if (a >= IOB && a < IOB + 2) m_err = 1;
            else if (a == IOB + 2) clrm = wd[1:0];
            else if (a == IOB + 3) m_out[0] = wd;
            else if (a == IOB + 4) m_out[1] = wd;
            else m_err = 1;
            if (re) m_err = 1;
            m_rvalid = 0;
        end else if (re) begin
            m_rvalid = 1;
            m_rknown = 1;
            if (a < 256) begin
                m_rdata = m_ram[a];
                m_rknown = m_known[a];
            end else if (a == IOB || a == IOB + 1) begin
                m_rdata = m_shadow[a - IOB];
                clrm[a - IOB] = 1'b1;
            end else if (a == IOB + 2) m_rdata = {30'd0, old_pend};
            else if (a == IOB + 3) m_rdata = m_out[0];
            else if (a == IOB + 4) m_rdata = m_out[1];
            else begin
                m_rdata = '0;
                m_err = 1;
            end
        end else m_rvalid = 0;
        m_irq = |old_pend;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = (din[k*32 +: 32] != m_shadow[k])
                      | (old_pend[k] & ~clrm[k]);
            m_shadow[k] = din[k*32 +: 32];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        reset = 1'b0; mre = 0; mwe = 0;
        addr = '0; wdata = '0; in_data = '0;

        vec[0]  = mk(0,1,32'd5,32'hDEADBEEF,0,0, 0,32'h0,0,0,0);
        vec[1]  = mk(1,0,32'd5,0,0,0, 1,32'hDEADBEEF,0,0,0);
        vec[2]  = mk(0,0,32'd5,0,0,0, 0,32'hDEADBEEF,0,0,0);
        vec[3]  = mk(0,0,32'd0,0,32'h41,0, 0,32'hDEADBEEF,0,0,0);
        vec[4]  = mk(0,0,32'd0,0,32'h41,0, 0,32'hDEADBEEF,1,0,0);
        vec[5]  = mk(1,0,IOB,0,32'h41,0, 1,32'h41,1,0,0);
        vec[6]  = mk(1,0,IOB+2,0,32'h41,0, 1,32'h0,0,0,0);
        vec[7]  = mk(0,1,IOB+2,32'h2,32'h41,5, 0,32'h0,0,0,0);
        vec[8]  = mk(1,0,IOB+2,0,32'h41,5, 1,32'h2,1,0,0);
        vec[9]  = mk(1,0,IOB+1,0,32'h41,5, 1,32'h5,1,0,0);
        vec[10] = mk(1,0,IOB+2,0,32'h41,5, 1,32'h0,0,0,0);
        vec[11] = mk(1,0,IOB+1,0,32'h41,7, 1,32'h5,0,0,0);
        vec[12] = mk(1,0,IOB+2,0,32'h41,7, 1,32'h2,1,0,0);
        vec[13] = mk(0,1,IOB+2,32'h2,32'h41,7, 0,32'h2,1,0,0);
        vec[14] = mk(0,1,IOB+4,32'h00FF00FF,32'h41,7,
                     0,32'h2,0,0,32'h00FF00FF);
        vec[15] = mk(1,0,IOB+4,0,32'h41,7,
                     1,32'h00FF00FF,0,0,32'h00FF00FF);
        vec[16] = mk(1,0,IOB+50,0,32'h41,7, 1,32'h0,0,1,32'h00FF00FF);
        vec[17] = mk(1,1,32'd3,32'h1234,32'h41,7,
                     0,32'h0,0,1,32'h00FF00FF);
        vec[18] = mk(1,0,32'd3,0,32'h41,7, 1,32'h1234,0,1,32'h00FF00FF);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_out", out_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", bus_err, 0);
        reset = 1'b1;

        foreach (vec[i]) begin
            mre = vec[i].re; mwe = vec[i].we;
            addr = vec[i].a; wdata = vec[i].wd;
            in_data = {vec[i].in1, vec[i].in0};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), rvalid, vec[i].ev);
            chk($sformatf("v%0d_rdata", i), rdata, vec[i].ed);
            chk($sformatf("v%0d_irq", i), irq, vec[i].eirq);
            chk($sformatf("v%0d_err", i), bus_err, vec[i].eerr);
            chk($sformatf("v%0d_out", i), out_data,
                {vec[i].eout1, 32'h0});
        end

        // Asynchronous reset while a read result is being presented
        mre = 1; mwe = 0; addr = 32'd5;
        #2 reset = 1'b0;
        #1;
        chk("arst_rvalid", rvalid, 0);
        chk("arst_out", out_data, 0);
        chk("arst_err", bus_err, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_irq", irq, 0);
        @(posedge clk);
        #1;
        chk("arst_hold_rvalid", rvalid, 0);
        mre = 0; in_data = '0;
        reset = 1'b1;
        mre = 1; addr = 32'd5;
        @(posedge clk);
        #1;
        chk("ram_keep_rvalid", rvalid, 1);
        chk("ram_keep_rdata", rdata, 32'hDEADBEEF);
        mre = 0;

        // Randomized run; nonzero input present at reset release
        reset = 1'b0;
        in_data = {32'h0, 32'h99};
        #1;
        m_ram[5] = 32'hDEADBEEF; m_known[5] = 1;
        m_ram[3] = 32'h1234;     m_known[3] = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int sel;
            mre = 1'($urandom_range(0, 1));
            mwe = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4) addr = $urandom_range(0, 7);
            else if (sel < 9) addr = IOB + 32'(sel - 4);
            else addr = ($urandom_range(0, 1) != 0) ? IOB + 50 : 32'd256;
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0)
                in_data[31:0] = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                in_data[63:32] = $urandom_range(0, 3);
            @(posedge clk);
            model_edge(mre, mwe, addr, wdata, in_data);
            #1;
            chk($sformatf("r%0d_rvalid", i), rvalid, m_rvalid);
            if (m_rknown)
                chk($sformatf("r%0d_rdata", i), rdata, m_rdata);
            chk($sformatf("r%0d_irq", i), irq, m_irq);
            chk($sformatf("r%0d_err", i), bus_err, m_err);
            chk($sformatf("r%0d_out", i), out_data,
                {m_out[1], m_out[0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
